// File: rtl/scratch_arb_pkg.sv
// scratch_arb_pkg
// Shared types and defaults for the scratch RAM arbiter.
//   arb_state_t       : arbiter FSM state encoding
//   SCR_ARB_MAX_WAIT  : default number of consecutive debug denials before
//                       the pipeline is stalled for one cycle
package scratch_arb_pkg;

    localparam int SCR_ARB_MAX_WAIT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_STEAL
    } arb_state_t;

endpackage

// File: rtl/scratch_arbiter_sat_counter.sv
// sat_counter
// Saturating up-counter used to count consecutive debug denials.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : count up by one, saturating at MAX
//   cnt      : current count
//   at_max   : count is at MAX, or reaches MAX with the increment this cycle
module sat_counter
    import scratch_arb_pkg::*;
#(
    parameter int MAX = SCR_ARB_MAX_WAIT,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    // at_max looks one increment ahead so the owner can react in the same
    // cycle the count reaches MAX instead of one cycle later.
    always_comb begin
        at_max = (cnt == W'(MAX)) || (inc && (cnt == W'(MAX - 1)));
    end

    // Count register; holds at MAX rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scratch_arbiter.sv
// scratch_arbiter
// Shares the single-port scratch RAM between the CPU execute stage (priority)
// and a debug/DMA requester. After MAX_WAIT consecutive denials the debug
// port steals one cycle and the pipeline is stalled for that cycle.
// Ports:
//   clk, rst                                  : clock, synchronous active-high reset
//   cpu_active/cpu_we/cpu_addr/cpu_wdata      : execute-stage access
//   cpu_rdata                                 : RAM read data passthrough
//   cpu_stall                                 : execute stage must hold this cycle
//   dbg_req/dbg_we/dbg_addr/dbg_wdata         : debug access request
//   dbg_gnt                                   : debug access performed this cycle
//   dbg_rdata/dbg_rvalid                      : registered debug read data
//   ram_we/ram_addr/ram_wdata/ram_rdata       : scratch RAM port
module scratch_arbiter
    import scratch_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 10,
    parameter int MAX_WAIT = SCR_ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_active,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] deny_cnt;
    logic             deny_at_max;
    logic             cpu_denied;

    // A denial is any debug request that loses to an active CPU outside the
    // steal slot. Every non-denied cycle clears the counter, so it only ever
    // holds a run of consecutive denials.
    sat_counter #(
        .MAX (MAX_WAIT)
    ) u_deny_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!cpu_denied),
        .inc    (cpu_denied),
        .cnt    (deny_cnt),
        .at_max (deny_at_max)
    );

    // Grant, stall and RAM mux. cpu_stall decodes registered state only; the
    // grant is combinational so an idle CPU lets debug in the same cycle.
    // Everything is held inactive while reset is asserted.
    always_comb begin
        cpu_stall  = !rst && (state == ARB_STEAL);
        dbg_gnt    = !rst && dbg_req && ((state == ARB_STEAL) || !cpu_active);
        cpu_denied = !rst && dbg_req && cpu_active && (state != ARB_STEAL);
        cpu_rdata  = ram_rdata;
        if (dbg_gnt) begin
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end else begin
            ram_we    = !rst && cpu_active && !cpu_stall && cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    // Arbiter FSM. STEAL always lasts exactly one cycle and is only entered
    // from a denial, which cannot happen in STEAL, so stalls never abut.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE, ARB_WAIT: begin
                    if (cpu_denied) begin
                        state <= deny_at_max ? ARB_STEAL : ARB_WAIT;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Debug read data is captured from the RAM during the granted cycle and
    // presented with a one-cycle valid pulse afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= ram_rdata;
            end
        end
    end

    // The counter must be empty whenever the FSM rests in IDLE.
    idle_count_clear : assert property (@(posedge clk) disable iff (rst)
        (state == ARB_IDLE) |-> (deny_cnt == '0));

endmodule

// File: doc/scratch_arbiter.md
# scratch_arbiter

Shares the single-port scratch RAM (SCR) between the CPU execute stage and an external debug/DMA requester. The CPU has priority. A starvation counter guarantees the debug port a slot by stalling the pipeline for one cycle after `MAX_WAIT` consecutive denials. The block sits between the execute-stage scratch address/data muxes and `SCRATCH_RAM`, and its `cpu_stall` output feeds pipeline control.

## Interface
Parameters:
- `ADDR_W`, default 8: scratch address width.
- `DATA_W`, default 10: scratch data width, wide enough for return addresses.
- `MAX_WAIT`, default 16: consecutive denied cycles before a forced steal. Legal range ≥ 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_active` in 1: the execute-stage instruction accesses SCR this cycle.
- `cpu_we` in 1: execute-stage write enable.
- `cpu_addr` in ADDR_W: execute-stage address.
- `cpu_wdata` in DATA_W: execute-stage write data.
- `cpu_rdata` out DATA_W: combinational passthrough of `ram_rdata`.
- `cpu_stall` out 1: execute stage must hold; its SCR access is suppressed this cycle and is re-presented next cycle.
- `dbg_req` in 1: debug access request, level-held until granted.
- `dbg_we` in 1: debug write enable.
- `dbg_addr` in ADDR_W: debug address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_gnt` out 1: debug access is performed this cycle (one-cycle pulse per access).
- `dbg_rdata` out DATA_W: registered read data.
- `dbg_rvalid` out 1: `dbg_rdata` is valid (one-cycle pulse).
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM asynchronous read data.

## Operation
State machine states are IDLE, WAIT and STEAL. A saturating denial counter `deny_cnt` is `$clog2(MAX_WAIT+1)` bits wide.

- **IDLE:**
  - `dbg_req & !cpu_active`: `dbg_gnt=1`, debug owns the RAM; stay in IDLE.
  - `dbg_req & cpu_active`: denied; CPU owns the RAM; `deny_cnt<=1`.
    - Go to STEAL if `MAX_WAIT==1`, otherwise go to WAIT.
- **WAIT:**
  - `!dbg_req` (request withdrawn): go to IDLE, `deny_cnt<=0`.
  - `!cpu_active`: grant the debug access; go to IDLE, `deny_cnt<=0`.
  - Otherwise: denied; `deny_cnt++`. When the new value equals `MAX_WAIT`, go to STEAL.
- **STEAL:**
  - `cpu_stall=1` and `cpu_active` is ignored.
  - If `dbg_req`, grant the debug access.
  - Unconditionally go to IDLE, `deny_cnt<=0`.
- **RAM mux:**
  - When debug owns the RAM, `ram_*` is driven from `dbg_*`. Otherwise it is driven from `cpu_*`.
  - `ram_we` is the selected owner's write enable, gated by its grant:
    - The CPU write is gated by `cpu_active & !cpu_stall`.
    - The debug write is gated by `dbg_gnt`.
  - With no active owner, `ram_we=0`.
- **Debug reads:** on a granted read (`dbg_gnt & !dbg_we`), register `ram_rdata` into `dbg_rdata` and pulse `dbg_rvalid` on the next cycle. Writes never assert `dbg_rvalid`.
- **Reset:**
  - State returns to IDLE; `deny_cnt=0`.
  - `cpu_stall=0`, `dbg_gnt=0`, `dbg_rvalid=0`, `dbg_rdata=0`, `ram_we=0`.
  - Reset mid-WAIT or mid-STEAL discards the pending grant.

## Timing
- `cpu_stall` is a decode of registered state only, so there is no combinational path from `cpu_active`.
- `cpu_stall` is never asserted on two consecutive cycles.
- `dbg_gnt` is combinational from `dbg_req`, `cpu_active` and state.
- Latency, uncontended: grant in the same cycle as `dbg_req`. Read data valid 1 cycle after the grant.
- Latency, worst case under continuous `cpu_active`: grant in cycle `MAX_WAIT` after `dbg_req` rises at cycle 0.
- After a grant, the requester must drop `dbg_req` or present a new request. A still-asserted `dbg_req` on the following cycle is a new access.
- Simultaneous `cpu_active` and STEAL: the CPU loses the slot and must re-present its access next cycle.

## Structure
- Package `scratch_arb_pkg` holds `typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_STEAL} arb_state_t` and a default `MAX_WAIT` constant `SCR_ARB_MAX_WAIT = 16`.
- One sub-module, `sat_counter` (parameter `MAX`; ports `clr`, `inc`, `cnt`, `at_max`), implements `deny_cnt`.
- The arbiter FSM and RAM mux live in `scratch_arbiter`.

## Test plan
- Uncontended read: RAM[0x20]=0x155, `cpu_active=0`, `dbg_req`/read of 0x20 at cycle 0 → `dbg_gnt=1` at cycle 0; `dbg_rvalid=1` and `dbg_rdata=0x155` at cycle 1; `cpu_stall` stays 0.
- CPU priority: `cpu_active=1` for cycles 0–2 (write 0x0AA to 0x10), debug write 0x3FF to 0x10 requested at cycle 0, `MAX_WAIT=16` → `dbg_gnt` first at cycle 3; RAM[0x10]=0x3FF afterwards.
- Starvation steal: `MAX_WAIT=4`, `cpu_active=1` continuously, `dbg_req` held from cycle 0 → `cpu_stall=1` and `dbg_gnt=1` at cycle 4 only, `ram_we` from the CPU suppressed at cycle 4; `cpu_stall=0` at cycle 5.
- Back-to-back requests under load: `MAX_WAIT=2`, `cpu_active=1`, `dbg_req` held for 2 accesses → steals at cycles 2 and 5 with no adjacent stall cycles.
- Withdrawal: `dbg_req` asserted cycles 0–1 with `cpu_active=1`, then dropped → state IDLE at cycle 3, `deny_cnt=0`, no grant, no stall.
- Reset mid-WAIT: `rst` at cycle 3 of a contended request (`MAX_WAIT=4`) → no steal at cycle 4; all outputs 0 during reset.
